// File: rtl/axis_wide_to_byte_framer.sv
// Wide-to-byte AXI-Stream serializer with frame re-delimiting.
// One word is held at a time and its bytes are sent one per beat.
// Frames end on a programmable byte count (frame_len) or on the
// input in_last marker, whichever comes first.
module axis_wide_to_byte_framer #(
  parameter int IN_BYTES  = 4,
  parameter int LEN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [8*IN_BYTES-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  byte_order,
  output logic [15:0]           frames_sent,
  output logic                  short_frame
);

  localparam int IDX_W = (IN_BYTES > 2) ? $clog2(IN_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_BYTES - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]            state_reg;
  logic [8*IN_BYTES-1:0] word_reg;
  logic [IDX_W-1:0]      byte_idx_reg;
  logic                  last_reg;
  logic                  order_reg;
  logic [LEN_WIDTH-1:0]  byte_cnt_reg;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [15:0]           frames_reg;
  logic                  short_reg;

  logic [7:0]            byte_lane [IN_BYTES];
  logic [IDX_W-1:0]      sel_idx;
  logic [LEN_WIDTH-1:0]  len_eff;
  logic                  sending;
  logic                  final_byte;
  logic                  beat;
  logic                  len_hit;
  logic                  in_hit;
  logic                  accept;

  // Split the held word into byte lanes; lane 0 is in_data[7:0].
  for (genvar gi = 0; gi < IN_BYTES; gi++) begin : g_lane
    assign byte_lane[gi] = word_reg[8*gi +: 8];
  end

  assign sending    = (state_reg == SEND);
  assign final_byte = (byte_idx_reg == LAST_IDX);
  assign beat       = sending && out_ready;
  assign sel_idx    = order_reg ? byte_idx_reg : (LAST_IDX - byte_idx_reg);

  // On the first beat of a frame the length has not been latched yet,
  // so the live frame_len is used; afterwards the latched copy governs.
  assign len_eff = (byte_cnt_reg == '0) ? frame_len : len_reg;
  assign len_hit = (len_eff != '0) && (byte_cnt_reg == len_eff - LEN_WIDTH'(1));
  assign in_hit  = last_reg && final_byte;

  assign out_valid   = sending;
  assign out_data    = sending ? byte_lane[sel_idx] : 8'h00;
  assign out_last    = sending && (len_hit || in_hit);
  assign in_ready    = !reset && (!sending || (final_byte && out_ready));
  assign accept      = in_valid && in_ready;
  assign frames_sent = frames_reg;
  assign short_frame = short_reg;

  // Holding register and byte walker: load on accept, step on each beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      word_reg     <= '0;
      byte_idx_reg <= '0;
      last_reg     <= 1'b0;
      order_reg    <= 1'b0;
    end else if (accept) begin
      state_reg    <= SEND;
      word_reg     <= in_data;
      byte_idx_reg <= '0;
      last_reg     <= in_last;
      order_reg    <= byte_order;
    end else if (beat) begin
      if (final_byte) begin
        state_reg <= IDLE;
      end else begin
        byte_idx_reg <= byte_idx_reg + IDX_W'(1);
      end
    end
  end

  // Frame byte counter and length latch, advanced per accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_reg <= '0;
      len_reg      <= '0;
    end else if (beat) begin
      if (byte_cnt_reg == '0) begin
        len_reg <= frame_len;
      end
      if (out_last) begin
        byte_cnt_reg <= '0;
      end else begin
        byte_cnt_reg <= byte_cnt_reg + LEN_WIDTH'(1);
      end
    end
  end

  // Frame statistics: wrapping frame count and short-frame pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      frames_reg <= '0;
      short_reg  <= 1'b0;
    end else begin
      short_reg <= beat && in_hit && !len_hit && (len_eff != '0);
      if (beat && out_last) begin
        frames_reg <= frames_reg + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_wide_to_byte_framer.sv
// Scoreboard bench for axis_wide_to_byte_framer (IN_BYTES=4).
// Stimulus pushes expected bytes into a queue on word acceptance;
// an independent monitor pops and compares on every output beat.
module tb_axis_wide_to_byte_framer;

  localparam int IB = 4;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] frame_len;
  logic        byte_order;
  logic [15:0] frames_sent;
  logic        short_frame;

  axis_wide_to_byte_framer #(.IN_BYTES(IB), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_len(frame_len), .byte_order(byte_order),
    .frames_sent(frames_sent), .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];
  int   m_cnt = 0;
  int   m_len = 0;
  int   exp_short = 0;
  int   seen_short = 0;
  int   beats = 0;
  int   last_pop_cyc = 0;
  int   last_accept_cyc = 0;
  bit   toggle_mode = 0;
  bit   verbose = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Expected bytes of one word, framed by length and in_last.
  task automatic push_word(input logic [31:0] w, input logic last, input logic ord);
    for (int i = 0; i < IB; i++) begin
      logic [7:0] b;
      int len;
      bit lh;
      bit ih;
      bit el;
      b = ord ? w[8*i +: 8] : w[8*(IB-1-i) +: 8];
      if (m_cnt == 0) m_len = int'(frame_len);
      len = m_len;
      lh = (len != 0) && (m_cnt == len - 1);
      ih = last && (i == IB - 1);
      el = lh || ih;
      if (ih && !lh && len != 0) exp_short++;
      m_cnt = el ? 0 : m_cnt + 1;
      q.push_back(exp_t'({b, el}));
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic last);
    int waited;
    waited = 0;
    in_data  = w;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 for word %h", w);
    end else begin
      push_word(w, last, byte_order);
      last_accept_cyc = cyc;
      if (verbose)
        $display("word %h last=%0d order=%0d len=%0d accepted cyc=%0d",
                 w, last, byte_order, frame_len, cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_last  = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain: got %0d pending bytes want 0", name, q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Cycle counter, advanced on each rising edge.
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Optional out_ready toggling for backpressure tests.
  initial forever begin
    @(posedge clk);
    #1;
    if (toggle_mode) out_ready = ~out_ready;
  end

  // Monitor: compare each output beat with the scoreboard head.
  initial begin
    bit         stall_prev;
    logic [7:0] prev_d;
    logic       prev_l;
    exp_t       e;
    stall_prev = 0;
    prev_d = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (stall_prev && out_valid) begin
          check("hold_data", 32'(out_data), 32'(prev_d));
          check("hold_last", 32'(out_last), 32'(prev_l));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got byte %h want none", out_data);
          end else begin
            e = q.pop_front();
            check("out_data", 32'(out_data), 32'(e.d));
            check("out_last", 32'(out_last), 32'(e.l));
          end
          beats++;
          last_pop_cyc = cyc;
        end
        if (short_frame) seen_short++;
        stall_prev = out_valid && !out_ready;
        prev_d = out_data;
        prev_l = out_last;
      end else begin
        stall_prev = 0;
      end
    end
  end

  initial begin
    int f0;
    int s0;
    int b0;
    int c0;
    int n;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    frame_len  = '0;
    byte_order = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_short", 32'(short_frame), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_frames", 32'(frames_sent), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(in_ready), 1);

    // MSB-first single word, in_last delimited: 11,22,33,44(last)
    send_word(32'h11223344, 1'b1);
    wait_drain("msb");
    check("frames_after_msb", 32'(frames_sent), 1);

    // LSB-first with out_ready toggling: 44,33,22,11 within 8 cycles
    byte_order = 1'b1;
    toggle_mode = 1;
    send_word(32'h11223344, 1'b1);
    wait_drain("lsb");
    toggle_mode = 0;
    out_ready = 1'b1;
    check("lsb_within_8", 32'((last_pop_cyc - last_accept_cyc) <= 8), 1);
    check("frames_after_lsb", 32'(frames_sent), 2);

    // Length framing: 512 words, 1024-byte frames, no bubbles
    byte_order = 1'b0;
    frame_len = 16'd1024;
    f0 = frames_sent;
    s0 = seen_short;
    verbose = 0;
    c0 = 0;
    for (int k = 0; k < 512; k++) begin
      send_word(32'h01010101 * k + 32'h00102030, 1'b0);
      if (k == 0) c0 = last_accept_cyc;
    end
    wait_drain("len1024");
    verbose = 1;
    $display("stream of 512 words, frame_len=1024, done cyc=%0d", cyc);
    check("len1024_frames", 32'(frames_sent - 16'(f0)), 2);
    check("len1024_no_bubble", 32'(last_pop_cyc - c0), 2048);
    check("len1024_no_short", 32'(seen_short - s0), 0);

    // Mid-word boundary: frame of 6, then 2-byte short frame
    frame_len = 16'd6;
    f0 = frames_sent;
    s0 = seen_short;
    send_word(32'hA1A2A3A4, 1'b0);
    send_word(32'hB1B2B3B4, 1'b1);
    wait_drain("len6");
    check("len6_frames", 32'(frames_sent - 16'(f0)), 2);
    check("len6_short", 32'(seen_short - s0), 1);

    // Reset after 3 of 4 bytes of a word
    frame_len = 16'd0;
    b0 = beats;
    send_word(32'hC1C2C3C4, 1'b1);
    n = 0;
    while (beats < b0 + 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midrst_3_beats", 32'(beats - b0), 3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_last", 32'(out_last), 0);
    check("midrst_frames", 32'(frames_sent), 0);
    q.delete();
    m_cnt = 0;
    reset = 1'b0;
    #1;
    $display("reset mid-frame applied, cyc=%0d", cyc);
    // Following frame: D1,D2,D3(last by length), D4(last by in_last, short)
    frame_len = 16'd3;
    s0 = seen_short;
    send_word(32'hD1D2D3D4, 1'b1);
    wait_drain("postrst");
    check("postrst_frames", 32'(frames_sent), 2);
    check("postrst_short", 32'(seen_short - s0), 1);

    // Wrap: 65536 one-byte frames from a fresh reset
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_cnt = 0;
    frame_len = 16'd1;
    b0 = beats;
    verbose = 0;
    for (int k = 0; k < 16384; k++) begin
      send_word(32'hFFFFFFFF - k, 1'b0);
      if (k == 8191) begin
        wait_drain("wrap_half");
        check("wrap_half_frames", 32'(frames_sent), 32768);
      end
      if (k == 16382) begin
        wait_drain("wrap_pre");
        check("wrap_pre_frames", 32'(frames_sent), 65532);
      end
    end
    wait_drain("wrap");
    verbose = 1;
    $display("stream of 65536 one-byte frames done, cyc=%0d", cyc);
    check("wrap_frames", 32'(frames_sent), 0);
    check("wrap_beats", 32'(beats - b0), 65536);
    check("short_total", 32'(seen_short), 32'(exp_short));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
